// File: rtl/sa_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : sa_out_requant
// Purpose  : Output drain for the SA systolic array. Buffers channel rows in
//            a small FIFO, then per lane adds the channel bias, applies a
//            round-half-up arithmetic right shift and saturates to int8.
//            Rows leave on a valid/ready stream.
// Options  : SA_OUT_RELU_EN - clamp negative results to 0 (output [0,127]).
// Revision : 1.0 - initial release
// ============================================================================
module sa_out_requant #(
  parameter int COLUMN_NUM  = 32,
  parameter int PIXEL_WIDTH = 20,
  parameter int BIAS_WIDTH  = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int CH_WIDTH    = 6
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode,
  input  logic [4:0]                          shift_88,
  input  logic [4:0]                          shift_18,
  input  logic                                channel_out_reset,
  input  logic                                channel_out_en,
  input  logic [PIXEL_WIDTH*2*COLUMN_NUM-1:0] sa_out,
  input  logic [CH_WIDTH-1:0]                 num_ch,
  output logic [CH_WIDTH-1:0]                 ch_idx,
  input  logic [BIAS_WIDTH-1:0]               bias_in,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [8*2*COLUMN_NUM-1:0]           m_data,
  output logic                                m_last,
  output logic                                overflow
);

  localparam int LANES = 2 * COLUMN_NUM;
  localparam int ROW_W = PIXEL_WIDTH * LANES;
  localparam int SUM_W = PIXEL_WIDTH + 1;
  // One extra bit so the rounding offset can never wrap the sum.
  localparam int RND_W = PIXEL_WIDTH + 2;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [4:0]              c_SH_MAX  = 5'(PIXEL_WIDTH);
  localparam logic signed [RND_W-1:0] c_SAT_MAX = RND_W'(127);
  localparam logic signed [RND_W-1:0] c_SAT_MIN = RND_W'(-128);

  // FIFO storage and bookkeeping
  logic [ROW_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Stage 1 registers
  logic                   r_s1_valid;
  logic [LANES*SUM_W-1:0] r_s1_sum;
  logic [4:0]             r_s1_sh;
  logic                   r_s1_last;

  logic                   w_full;
  logic                   w_empty;
  logic                   w_s2_adv;
  logic                   w_s1_adv;
  logic                   w_pop;
  logic                   w_push;
  logic [ROW_W-1:0]       w_head;
  logic [4:0]             w_sh_sel;
  logic [4:0]             w_sh_clamp;
  logic                   w_last_hit;
  logic signed [RND_W-1:0] w_half;
  logic [LANES*SUM_W-1:0] w_sum_flat;
  logic [LANES*8-1:0]     w_s2_data;

  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_s2_adv   = !m_valid || m_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign w_pop      = !w_empty && w_s1_adv;
  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign w_push     = channel_out_en && (!w_full || w_pop);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_sh_sel   = mode ? shift_18 : shift_88;
  assign w_sh_clamp = (w_sh_sel > c_SH_MAX) ? c_SH_MAX : w_sh_sel;
  assign w_last_hit = (ch_idx == num_ch);
  assign w_half     = (r_s1_sh == 5'd0) ? '0 : (RND_W'(1) << (r_s1_sh - 5'd1));

  // Per-lane datapath: bias add feeding S1, round/shift/saturate feeding S2.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [PIXEL_WIDTH-1:0] w_pix;
    logic signed [SUM_W-1:0]       w_sum;
    logic signed [SUM_W-1:0]       w_s1q;
    logic signed [RND_W-1:0]       w_rnd;
    logic signed [RND_W-1:0]       w_shr;
    logic [7:0]                    w_sat;
    logic [7:0]                    w_res;

    assign w_pix = w_head[k*PIXEL_WIDTH +: PIXEL_WIDTH];
    assign w_sum = SUM_W'(w_pix) + SUM_W'($signed(bias_in));
    assign w_sum_flat[k*SUM_W +: SUM_W] = w_sum;

    assign w_s1q = r_s1_sum[k*SUM_W +: SUM_W];
    assign w_rnd = RND_W'(w_s1q) + w_half;
    assign w_shr = w_rnd >>> r_s1_sh;
    assign w_sat = (w_shr > c_SAT_MAX) ? 8'h7F :
                   (w_shr < c_SAT_MIN) ? 8'h80 : w_shr[7:0];
`ifdef SA_OUT_RELU_EN
    assign w_res = w_sat[7] ? 8'h00 : w_sat;
`else
    assign w_res = w_sat;
`endif
    assign w_s2_data[k*8 +: 8] = w_res;
  end

  // FIFO row storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= sa_out;
  end

  // FIFO pointers and occupancy; a tile restart empties the FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (channel_out_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Stage 1: capture biased sums, clamped shift and last flag for the popped row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_sh    <= '0;
      r_s1_last  <= 1'b0;
    end else if (channel_out_reset) begin
      r_s1_valid <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_sh    <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_pop;
      if (w_pop) begin
        r_s1_sum  <= w_sum_flat;
        r_s1_sh   <= w_sh_clamp;
        r_s1_last <= w_last_hit;
      end
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (channel_out_reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_last  <= 1'b0;
    end else if (w_s2_adv) begin
      m_valid <= r_s1_valid;
      m_data  <= r_s1_valid ? w_s2_data : '0;
      m_last  <= r_s1_valid && r_s1_last;
    end
  end

  // Channel counter: advances per row entering S1, wraps after num_ch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_idx <= '0;
    end else if (channel_out_reset) begin
      ch_idx <= '0;
    end else if (w_pop) begin
      ch_idx <= w_last_hit ? '0 : ch_idx + CH_WIDTH'(1);
    end
  end

  // Sticky drop flag: a row arrived with no free slot; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (channel_out_en && w_full && !w_pop && !channel_out_reset) begin
      overflow <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sa_out_requant.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa_out_requant
// Purpose  : Self-checking bench for sa_out_requant with a high-level
//            arithmetic reference model and a stream collector.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa_out_requant;

  localparam int CN    = 32;
  localparam int PW    = 20;
  localparam int BW    = 16;
  localparam int CW    = 6;
  localparam int LANES = 2 * CN;
  localparam int IN_W  = PW * LANES;
  localparam int OUT_W = 8 * LANES;
`ifdef SA_OUT_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             mode = 1'b0;
  logic [4:0]       shift_88 = '0;
  logic [4:0]       shift_18 = '0;
  logic             channel_out_reset = 1'b0;
  logic             channel_out_en = 1'b0;
  logic [IN_W-1:0]  sa_out = '0;
  logic [CW-1:0]    num_ch = '0;
  logic [CW-1:0]    ch_idx;
  logic [BW-1:0]    bias_in;
  logic             m_valid;
  logic             m_ready = 1'b0;
  logic [OUT_W-1:0] m_data;
  logic             m_last;
  logic             overflow;

  logic signed [BW-1:0] bias_tab [64];
  int n_cmp = 0;
  int n_bad = 0;
  int m_ch  = 0;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic             last;
  } row_t;

  row_t obs_q[$];

  sa_out_requant dut (
    .clk(clk), .reset(reset), .mode(mode), .shift_88(shift_88), .shift_18(shift_18),
    .channel_out_reset(channel_out_reset), .channel_out_en(channel_out_en),
    .sa_out(sa_out), .num_ch(num_ch), .ch_idx(ch_idx), .bias_in(bias_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Bias table lookup, combinational as the consumer of ch_idx would do.
  assign bias_in = bias_tab[ch_idx];

  // Record every accepted output row (no checking here).
  always @(negedge clk) begin
    if (!reset && m_valid === 1'b1 && m_ready) obs_q.push_back({m_data, m_last});
  end

  // Reference for one lane: floor((v+b + 2^(sh-1)) / 2^sh), saturate, optional relu.
  function automatic logic [7:0] ref_lane(input longint v, input longint b, input int sh);
    longint s, d, q;
    int e;
    e = (sh > PW) ? PW : sh;
    s = v + b;
    if (e == 0) q = s;
    else begin
      d = longint'(1) << e;
      s = s + d / 2;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
    end
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    if (RELU && q < 0) q = 0;
    return q[7:0];
  endfunction

  // Expected output row for the next row in channel order.
  function automatic row_t model_row(input logic [IN_W-1:0] row);
    row_t r;
    int sh;
    longint b;
    sh = mode ? int'(shift_18) : int'(shift_88);
    b  = longint'(bias_tab[m_ch]);
    for (int k = 0; k < LANES; k++)
      r.data[k*8 +: 8] = ref_lane(longint'($signed(row[k*PW +: PW])), b, sh);
    r.last = (m_ch == int'(num_ch));
    m_ch = (m_ch == int'(num_ch)) ? 0 : m_ch + 1;
    return r;
  endfunction

  function automatic logic [IN_W-1:0] rand_row();
    logic [IN_W-1:0] r;
    logic [PW-1:0] v;
    for (int k = 0; k < LANES; k++) begin
      case ($urandom_range(0, 3))
        0:       v = PW'($urandom);
        1:       v = PW'($urandom_range(0, 600)) - PW'(300);
        default: v = PW'($urandom_range(0, 8000)) - PW'(4000);
      endcase
      r[k*PW +: PW] = v;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_chreset();
    channel_out_en = 1'b0;
    channel_out_reset = 1'b1;
    step();
    channel_out_reset = 1'b0;
    m_ch = 0;
  endtask

  task automatic wait_obs(input int n);
    for (int c = 0; c < 400 && obs_q.size() < n; c++) @(negedge clk);
  endtask

  task automatic send(input logic [IN_W-1:0] row);
    sa_out = row;
    channel_out_en = 1'b1;
    step();
    channel_out_en = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL reset_data: got %h want 0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b want 0", m_last); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_cmp++; if (ch_idx !== '0) begin n_bad++; $display("FAIL reset_ch_idx: got %0d want 0", ch_idx); end
    @(posedge clk); #1; reset = 1'b0; m_ch = 0;
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_release_valid: got %b want 0", m_valid); end
  endtask

  task automatic test_latency();
    logic [IN_W-1:0] row;
    logic [7:0] l0, l1;
    mode = 1'b0; shift_88 = 5'd4; num_ch = '0; bias_tab[0] = '0; m_ready = 1'b1;
    do_chreset();
    row = '0;
    row[0 +: PW]  = PW'(256);
    row[PW +: PW] = PW'(-256);
    send(row);
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL latency_t1: got %b want 0", m_valid); end
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL latency_t2: got %b want 0", m_valid); end
    @(negedge clk);
    l0 = m_data[7:0]; l1 = m_data[15:8];
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL latency_t3: got %b want 1", m_valid); end
    n_cmp++; if (l0 !== 8'h10) begin n_bad++; $display("FAIL latency_lane0: got %h want 10", l0); end
    n_cmp++; if (l1 !== (RELU ? 8'h00 : 8'hF0)) begin n_bad++; $display("FAIL latency_lane1: got %h want %h", l1, RELU ? 8'h00 : 8'hF0); end
    n_cmp++; if (m_last !== 1'b1) begin n_bad++; $display("FAIL latency_last: got %b want 1", m_last); end
    repeat (3) step();
    obs_q.delete();
  endtask

  task automatic test_rounding();
    logic [IN_W-1:0] row;
    row_t exp;
    mode = 1'b0; shift_88 = 5'd4; num_ch = '0; bias_tab[0] = '0; m_ready = 1'b1;
    do_chreset(); obs_q.delete();
    row = '0;
    row[0 +: PW] = PW'(24); row[PW +: PW] = PW'(23); row[2*PW +: PW] = PW'(-24);
    exp = model_row(row);
    send(row);
    wait_obs(1);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL round_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0].data[23:0] !== {(RELU ? 8'h00 : 8'hFF), 8'h01, 8'h02})
        begin n_bad++; $display("FAIL round_lanes: got %h want %h", obs_q[0].data[23:0], {(RELU ? 8'h00 : 8'hFF), 8'h01, 8'h02}); end
      n_cmp++; if (obs_q[0].data !== exp.data) begin n_bad++; $display("FAIL round_row: got %h want %h", obs_q[0].data, exp.data); end
    end
    repeat (2) step();
    obs_q.delete();
    shift_88 = 5'd0; bias_tab[0] = 16'sd3;
    row = '0; row[0 +: PW] = PW'(5);
    exp = model_row(row);
    send(row);
    wait_obs(1);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL round0_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0].data[15:0] !== 16'h0308) begin n_bad++; $display("FAIL round0_lanes: got %h want 0308", obs_q[0].data[15:0]); end
      n_cmp++; if (obs_q[0].data !== exp.data) begin n_bad++; $display("FAIL round0_row: got %h want %h", obs_q[0].data, exp.data); end
    end
    repeat (2) step();
    obs_q.delete();
  endtask

  task automatic test_saturation();
    logic [IN_W-1:0] row;
    row_t exp;
    mode = 1'b0; shift_88 = 5'd0; num_ch = '0; bias_tab[0] = '0; m_ready = 1'b1;
    do_chreset(); obs_q.delete();
    row = '0; row[0 +: PW] = PW'(20'h7FFFF); row[PW +: PW] = PW'(20'h80000);
    exp = model_row(row);
    send(row);
    wait_obs(1);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL sat_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0].data[15:0] !== {(RELU ? 8'h00 : 8'h80), 8'h7F})
        begin n_bad++; $display("FAIL sat_lanes: got %h want %h", obs_q[0].data[15:0], {(RELU ? 8'h00 : 8'h80), 8'h7F}); end
      n_cmp++; if (obs_q[0].data !== exp.data) begin n_bad++; $display("FAIL sat_row: got %h want %h", obs_q[0].data, exp.data); end
    end
    repeat (2) step();
    obs_q.delete();
    // Oversized shift in 1x8 mode behaves as a shift of PW.
    mode = 1'b1; shift_18 = 5'd31; bias_tab[0] = 16'sd32767;
    exp = model_row(row);
    send(row);
    wait_obs(1);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL clamp_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0].data[15:0] !== 16'h0001) begin n_bad++; $display("FAIL clamp_lanes: got %h want 0001", obs_q[0].data[15:0]); end
      n_cmp++; if (obs_q[0].data !== exp.data) begin n_bad++; $display("FAIL clamp_row: got %h want %h", obs_q[0].data, exp.data); end
    end
    repeat (2) step();
    obs_q.delete();
  endtask

  task automatic test_bias_index();
    logic [7:0] want [4];
    want[0] = 8'd10; want[1] = 8'd20; want[2] = 8'd30; want[3] = 8'd10;
    mode = 1'b0; shift_88 = 5'd0; num_ch = CW'(2); m_ready = 1'b1;
    bias_tab[0] = 16'sd10; bias_tab[1] = 16'sd20; bias_tab[2] = 16'sd30;
    do_chreset(); obs_q.delete();
    n_cmp++; if (ch_idx !== '0) begin n_bad++; $display("FAIL bias_ch_start: got %0d want 0", ch_idx); end
    for (int i = 0; i < 4; i++) send('0);
    wait_obs(4);
    n_cmp++; if (obs_q.size() != 4) begin n_bad++; $display("FAIL bias_count: got %0d want 4", obs_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (obs_q[i].data[7:0] !== want[i] || obs_q[i].data[OUT_W-1 -: 8] !== want[i])
          begin n_bad++; $display("FAIL bias_row%0d: got %h/%h want %h", i, obs_q[i].data[7:0], obs_q[i].data[OUT_W-1 -: 8], want[i]); end
        n_cmp++; if (obs_q[i].last !== (i == 2))
          begin n_bad++; $display("FAIL bias_last%0d: got %b want %b", i, obs_q[i].last, (i == 2)); end
      end
    end
    n_cmp++; if (ch_idx !== CW'(1)) begin n_bad++; $display("FAIL bias_ch_end: got %0d want 1", ch_idx); end
    repeat (2) step();
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    row_t exp[$];
    logic [IN_W-1:0] row;
    logic [OUT_W-1:0] hold;
    num_ch = CW'(5); mode = 1'b1; shift_18 = 5'($urandom_range(0, 10)); m_ready = 1'b0;
    for (int i = 0; i < 6; i++) bias_tab[i] = BW'($urandom);
    do_chreset(); obs_q.delete();
    for (int i = 0; i < 6; i++) begin
      row = rand_row();
      exp.push_back(model_row(row));
      sa_out = row; channel_out_en = 1'b1;
      step();
    end
    sa_out = rand_row();
    @(negedge clk);
    hold = m_data;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_no_overflow: got %b want 0", overflow); end
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", m_valid); end
    @(posedge clk); #1; channel_out_en = 1'b0;
    @(negedge clk);
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow: got %b want 1", overflow); end
    n_cmp++; if (m_data !== hold || m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %h want %h", m_data, hold); end
    // Release ready together with a write into the full FIFO.
    @(posedge clk); #1;
    row = rand_row();
    exp.push_back(model_row(row));
    sa_out = row; channel_out_en = 1'b1; m_ready = 1'b1;
    step();
    channel_out_en = 1'b0;
    wait_obs(7);
    n_cmp++; if (obs_q.size() != 7) begin n_bad++; $display("FAIL bp_count: got %0d want 7", obs_q.size()); end
    else begin
      for (int i = 0; i < 7; i++) begin
        n_cmp++; if (obs_q[i] !== exp[i])
          begin n_bad++; $display("FAIL bp_row%0d: got %h/%b want %h/%b", i, obs_q[i].data, obs_q[i].last, exp[i].data, exp[i].last); end
      end
      n_cmp++; if (obs_q[5].last !== 1'b1) begin n_bad++; $display("FAIL bp_last6: got %b want 1", obs_q[5].last); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL bp_sticky: got %b want 1", overflow); end
    repeat (2) step();
    obs_q.delete();
  endtask

  task automatic test_flush();
    logic [IN_W-1:0] row;
    row_t exp;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_row());
    step();
    sa_out = rand_row(); channel_out_en = 1'b1; channel_out_reset = 1'b1;
    step();
    channel_out_en = 1'b0; channel_out_reset = 1'b0; m_ch = 0;
    @(negedge clk);
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", m_valid); end
    n_cmp++; if (ch_idx !== '0) begin n_bad++; $display("FAIL flush_ch_idx: got %0d want 0", ch_idx); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL flush_overflow: got %b want 1", overflow); end
    @(posedge clk); #1; m_ready = 1'b1; obs_q.delete();
    repeat (8) step();
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL flush_empty: got %0d rows want 0", obs_q.size()); end
    row = rand_row();
    exp = model_row(row);
    send(row);
    wait_obs(1);
    n_cmp++; if (obs_q.size() != 1) begin n_bad++; $display("FAIL flush_after_count: got %0d want 1", obs_q.size()); end
    else begin
      n_cmp++; if (obs_q[0] !== exp) begin n_bad++; $display("FAIL flush_after_row: got %h want %h", obs_q[0].data, exp.data); end
    end
    repeat (2) step();
    obs_q.delete();
  endtask

  task automatic test_async_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_row());
    repeat (2) step();
    n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL areset_pre_valid: got %b want 1", m_valid); end
    #3 reset = 1'b1;
    #1;
    n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL areset_valid: got %b want 0", m_valid); end
    n_cmp++; if (m_data !== '0) begin n_bad++; $display("FAIL areset_data: got %h want 0", m_data); end
    n_cmp++; if (m_last !== 1'b0) begin n_bad++; $display("FAIL areset_last: got %b want 0", m_last); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL areset_overflow: got %b want 0", overflow); end
    n_cmp++; if (ch_idx !== '0) begin n_bad++; $display("FAIL areset_ch_idx: got %0d want 0", ch_idx); end
    repeat (2) step();
    reset = 1'b0; m_ch = 0;
    step();
    obs_q.delete();
  endtask

  task automatic test_random_stream();
    row_t exp[$];
    logic [IN_W-1:0] row;
    int sent, cyc;
    for (int r = 0; r < 3; r++) begin
      num_ch = CW'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) bias_tab[i] = BW'($urandom);
      mode = 1'($urandom); shift_88 = 5'($urandom); shift_18 = 5'($urandom);
      m_ready = 1'b1;
      do_chreset(); obs_q.delete(); exp.delete();
      sent = 0; cyc = 0;
      while ((sent < 40 || obs_q.size() < sent) && cyc < 3000) begin
        m_ready = ($urandom_range(0, 99) < 70);
        if (sent < 40 && (sent - obs_q.size()) < 6 && $urandom_range(0, 99) < 60) begin
          row = rand_row();
          exp.push_back(model_row(row));
          sa_out = row; channel_out_en = 1'b1; sent++;
        end else begin
          channel_out_en = 1'b0;
        end
        step(); cyc++;
      end
      channel_out_en = 1'b0; m_ready = 1'b1;
      n_cmp++; if (obs_q.size() != exp.size())
        begin n_bad++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs_q.size(), exp.size()); end
      else begin
        for (int i = 0; i < exp.size(); i++) begin
          n_cmp++; if (obs_q[i] !== exp[i])
            begin n_bad++; $display("FAIL rand%0d_row%0d: got %h/%b want %h/%b", r, i, obs_q[i].data, obs_q[i].last, exp[i].data, exp[i].last); end
        end
      end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL rand%0d_overflow: got %b want 0", r, overflow); end
      repeat (2) step();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) bias_tab[i] = '0;
    test_reset();
    test_latency();
    test_rounding();
    test_saturation();
    test_bias_index();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
`default_nettype wire
